// File: rtl/noritsuna_cnt_pkg.sv
// Shared types and default parameters for the noritsuna programmable counter.
package noritsuna_cnt_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_PSC_W = 4;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } cnt_mode_t;

endpackage

// File: rtl/noritsuna_cnt_prescaler.sv
// Prescaler: emits a step every prescale+1 running cycles. A clear restarts the
// count and suppresses the step for that cycle.
module noritsuna_cnt_prescaler
  import noritsuna_cnt_pkg::*;
#(
  parameter int unsigned PSC_W = DEF_PSC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic [PSC_W-1:0] i_prescale,
  output logic             o_step
);

  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] w_psc_d;

  // >= so that lowering prescale below the running value steps on the next cycle
  assign o_step = i_run & ~i_clr & (r_psc >= i_prescale);

  // Next prescaler value: clear wins, otherwise restart on step or count up
  always_comb begin
    w_psc_d = r_psc;
    if (i_clr) begin
      w_psc_d = '0;
    end else if (i_run) begin
      w_psc_d = o_step ? '0 : r_psc + 1'b1;
    end
  end

  // Prescaler state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_psc <= '0;
    end else begin
      r_psc <= w_psc_d;
    end
  end

endmodule

// File: rtl/noritsuna_counter_core.sv
// WIDTH-bit programmable counter: prescaler, runtime terminal value, up/down/
// bounce/hold modes, synchronous load, one-cycle wrap pulse and optional count
// capture. Define NORITSUNA_CNT_CAPTURE_EN to build the capture logic; without
// it cap_q/cap_evt are tied to zero and capture is ignored.
module noritsuna_counter_core
  import noritsuna_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned PSC_W = DEF_PSC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_top,
  input  logic [PSC_W-1:0] i_prescale,
  input  logic             i_capture,
  output logic [WIDTH-1:0] o_count,
  output logic             o_dir,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_cap_q,
  output logic             o_cap_evt
);

  cnt_mode_t        w_mode;
  logic             w_step;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic             r_dir;
  logic             w_dir_d;
  logic             r_wrap;
  logic             w_wrap_d;

  assign w_mode = cnt_mode_t'(i_mode);

  noritsuna_cnt_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (i_ena & (w_mode != MODE_HOLD)),
    .i_clr      (i_load),
    .i_prescale (i_prescale),
    .o_step     (w_step)
  );

  // Next count/dir/wrap: load has priority, otherwise advance on a step
  always_comb begin
    w_count_d = r_count;
    w_dir_d   = r_dir;
    w_wrap_d  = 1'b0;
    if (i_load) begin
      w_count_d = (i_load_val > i_top) ? i_top : i_load_val;
      if (w_mode == MODE_UP) begin
        w_dir_d = 1'b1;
      end else if (w_mode == MODE_DOWN) begin
        w_dir_d = 1'b0;
      end
    end else if (w_step) begin
      case (w_mode)
        MODE_UP: begin
          w_dir_d = 1'b1;
          if (r_count >= i_top) begin
            w_count_d = '0;
            w_wrap_d  = 1'b1;
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
        MODE_DOWN: begin
          w_dir_d = 1'b0;
          if (r_count == '0) begin
            w_count_d = i_top;
            w_wrap_d  = 1'b1;
          end else begin
            w_count_d = r_count - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (r_dir && (r_count >= i_top)) begin
            w_wrap_d = 1'b1;
            // Degenerate range: pin at zero and keep direction
            if (i_top == '0) begin
              w_count_d = '0;
            end else begin
              w_count_d = i_top - 1'b1;
              w_dir_d   = 1'b0;
            end
          end else if (!r_dir && (r_count == '0)) begin
            w_wrap_d = 1'b1;
            if (i_top != '0) begin
              w_count_d = {{(WIDTH-1){1'b0}}, 1'b1};
              w_dir_d   = 1'b1;
            end
          end else if (r_dir) begin
            w_count_d = r_count + 1'b1;
          end else begin
            w_count_d = r_count - 1'b1;
          end
        end
        default: begin
          w_count_d = r_count;
        end
      endcase
    end
  end

  // Counter state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_dir   <= 1'b1;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_dir   <= w_dir_d;
      r_wrap  <= w_wrap_d;
    end
  end

  assign o_count = r_count;
  assign o_dir   = r_dir;
  assign o_wrap  = r_wrap;

`ifdef NORITSUNA_CNT_CAPTURE_EN
  logic             r_cap_prev;
  logic             r_cap_evt;
  logic [WIDTH-1:0] r_cap_q;
  logic             w_cap_rise;

  assign w_cap_rise = i_capture & ~r_cap_prev;

  // Capture edge detector; latches the pre-edge count on a rising capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap_prev <= 1'b0;
      r_cap_evt  <= 1'b0;
      r_cap_q    <= '0;
    end else begin
      r_cap_prev <= i_capture;
      r_cap_evt  <= w_cap_rise;
      if (w_cap_rise) begin
        r_cap_q <= r_count;
      end
    end
  end

  assign o_cap_q   = r_cap_q;
  assign o_cap_evt = r_cap_evt;
`else
  logic w_unused_capture;
  assign w_unused_capture = i_capture;
  assign o_cap_q          = '0;
  assign o_cap_evt        = 1'b0;
`endif

endmodule

// File: tb/tb_noritsuna_counter_core.sv
// Directed bench for noritsuna_counter_core (WIDTH=8, PSC_W=4) with a
// behavioural reference model and hand-computed literal expectations.
module tb_noritsuna_counter_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] top = 8'd0;
  logic [3:0] prescale = 4'd0;
  logic       capture = 1'b0;
  logic [7:0] count;
  logic       dir;
  logic       wrap;
  logic [7:0] cap_q;
  logic       cap_evt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  noritsuna_counter_core #(
    .WIDTH (8),
    .PSC_W (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ena      (ena),
    .i_mode     (mode),
    .i_load     (load),
    .i_load_val (load_val),
    .i_top      (top),
    .i_prescale (prescale),
    .i_capture  (capture),
    .o_count    (count),
    .o_dir      (dir),
    .o_wrap     (wrap),
    .o_cap_q    (cap_q),
    .o_cap_evt  (cap_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle counter decides steps, count follows the mode rules
  int m_count = 0, m_dir = 1, m_wrap = 0, m_elapsed = 0;
  int m_cap_q = 0, m_cap_evt = 0, m_cap_prev = 0;
  int nc, nd, ne, nw;
  bit stp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0; m_dir <= 1; m_wrap <= 0; m_elapsed <= 0;
      m_cap_q <= 0; m_cap_evt <= 0; m_cap_prev <= 0;
    end else begin
      nc = m_count; nd = m_dir; ne = m_elapsed; nw = 0; stp = 1'b0;
      if (load) begin
        nc = (int'(load_val) > int'(top)) ? int'(top) : int'(load_val);
        ne = 0;
        if (mode == 2'd0) nd = 1;
        if (mode == 2'd1) nd = 0;
      end else if (ena && mode != 2'd3) begin
        if (m_elapsed >= int'(prescale)) begin
          stp = 1'b1;
          ne  = 0;
        end else begin
          ne = m_elapsed + 1;
        end
      end
      if (stp) begin
        if (mode == 2'd0) begin
          nd = 1;
          if (m_count >= int'(top)) begin nc = 0; nw = 1; end
          else nc = (m_count + 1) % 256;
        end else if (mode == 2'd1) begin
          nd = 0;
          if (m_count == 0) begin nc = int'(top); nw = 1; end
          else nc = m_count - 1;
        end else begin
          if (top == 8'd0 && ((m_dir == 1) || (m_count == 0))) begin
            nc = 0; nw = 1;
          end else if (m_dir == 1 && m_count >= int'(top)) begin
            nc = int'(top) - 1; nd = 0; nw = 1;
          end else if (m_dir == 0 && m_count == 0) begin
            nc = 1; nd = 1; nw = 1;
          end else begin
            nc = (m_dir == 1) ? (m_count + 1) % 256 : m_count - 1;
          end
        end
      end
      m_count <= nc; m_dir <= nd; m_wrap <= nw; m_elapsed <= ne;
`ifdef NORITSUNA_CNT_CAPTURE_EN
      m_cap_prev <= int'(capture);
      if (capture && m_cap_prev == 0) begin
        m_cap_q   <= m_count;
        m_cap_evt <= 1;
      end else begin
        m_cap_evt <= 0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_count", 32'(count), 32'(m_count));
      chk("cmp_dir", 32'(dir), 32'(m_dir));
      chk("cmp_wrap", 32'(wrap), 32'(m_wrap));
      chk("cmp_cap_q", 32'(cap_q), 32'(m_cap_q));
      chk("cmp_cap_evt", 32'(cap_evt), 32'(m_cap_evt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int down_cnt[15] = '{0, 0, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
  int bnc_cnt[7]   = '{1, 2, 3, 2, 1, 0, 1};
  int bnc_wrap[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int bnc_dir[7]   = '{1, 1, 1, 0, 0, 0, 1};

  initial begin
    ena = 1'b1; mode = 2'd0; top = 8'd5; prescale = 4'd0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("lit_reset_count", 32'(count), 32'd0);
    chk("lit_reset_dir", 32'(dir), 32'd1);
    chk("lit_reset_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;

    // Up, top=5, prescale=0
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("lit_up_count", 32'(count), 32'(i % 6));
      chk("lit_up_wrap", 32'(wrap), 32'(i == 6));
    end

    // Down, top=3, prescale=2
    mode = 2'd1; top = 8'd3; prescale = 4'd2;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("lit_down_count", 32'(count), 32'(down_cnt[k]));
      chk("lit_down_wrap", 32'(wrap), 32'(k == 2 || k == 14));
    end

    // Bounce, top=3, starting at 0 going up
    mode = 2'd0; load = 1'b1; load_val = 8'd0; prescale = 4'd0;
    tick();
    load = 1'b0; mode = 2'd2;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("lit_bnc_count", 32'(count), 32'(bnc_cnt[k]));
      chk("lit_bnc_wrap", 32'(wrap), 32'(bnc_wrap[k]));
      chk("lit_bnc_dir", 32'(dir), 32'(bnc_dir[k]));
    end
    // Bounce with top=0
    load = 1'b1; load_val = 8'd5; top = 8'd0;
    tick();
    chk("lit_bnc0_load", 32'(count), 32'd0);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_bnc0_count", 32'(count), 32'd0);
      chk("lit_bnc0_wrap", 32'(wrap), 32'd1);
    end

    // Load clamps to top and clears the prescaler
    mode = 2'd0; top = 8'd100; prescale = 4'd3;
    tick(); tick();
    load = 1'b1; load_val = 8'd200;
    tick();
    chk("lit_load_clamp", 32'(count), 32'd100);
    chk("lit_load_nowrap", 32'(wrap), 32'd0);
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("lit_load_psc_count", 32'(count), (k == 4) ? 32'd0 : 32'd100);
      chk("lit_load_psc_wrap", 32'(wrap), 32'(k == 4));
    end
    // Load with ena=0
    ena = 1'b0; load = 1'b1; load_val = 8'd42;
    tick();
    chk("lit_load_noena", 32'(count), 32'd42);
    load = 1'b0;
    tick(); tick();
    chk("lit_noena_frozen", 32'(count), 32'd42);

    // Top lowered below count in up mode
    ena = 1'b1; prescale = 4'd0; load = 1'b1; load_val = 8'd50;
    tick();
    load = 1'b0; top = 8'd10;
    tick();
    chk("lit_toplow_count", 32'(count), 32'd0);
    chk("lit_toplow_wrap", 32'(wrap), 32'd1);
    // Down mode above top decrements normally
    top = 8'd100; load = 1'b1;
    tick();
    load = 1'b0; mode = 2'd1; top = 8'd10;
    tick();
    chk("lit_down_above_top", 32'(count), 32'd49);
    chk("lit_down_above_wrap", 32'(wrap), 32'd0);

    // Hold freezes everything
    mode = 2'd3;
    tick(); tick(); tick();
    chk("lit_hold_count", 32'(count), 32'd49);
    chk("lit_hold_dir", 32'(dir), 32'd0);

    // Lowering prescale below the running prescaler value
    mode = 2'd0; top = 8'd100; prescale = 4'd7; load = 1'b1; load_val = 8'd0;
    tick();
    load = 1'b0;
    tick(); tick(); tick(); tick();
    chk("lit_psc_wait", 32'(count), 32'd0);
    prescale = 4'd1;
    tick();
    chk("lit_psc_lower", 32'(count), 32'd1);

    // Asynchronous reset mid-count (dir low beforehand)
    mode = 2'd1; prescale = 4'd0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("lit_arst_count", 32'(count), 32'd0);
    chk("lit_arst_dir", 32'(dir), 32'd1);
    chk("lit_arst_wrap", 32'(wrap), 32'd0);
    tick();
    rst_n = 1'b1; mode = 2'd0; prescale = 4'd1;
    tick();
    chk("lit_rst_resume0", 32'(count), 32'd0);
    tick();
    chk("lit_rst_resume1", 32'(count), 32'd1);

    // Capture coinciding with a pending step
    prescale = 4'd0; load = 1'b1; load_val = 8'd7;
    tick();
    load = 1'b0; capture = 1'b1;
    tick();
    chk("lit_cap_step", 32'(count), 32'd8);
`ifdef NORITSUNA_CNT_CAPTURE_EN
    chk("lit_cap_q", 32'(cap_q), 32'd7);
    chk("lit_cap_evt", 32'(cap_evt), 32'd1);
`else
    chk("lit_cap_q_off", 32'(cap_q), 32'd0);
    chk("lit_cap_evt_off", 32'(cap_evt), 32'd0);
`endif
    tick();
    chk("lit_cap_evt_once", 32'(cap_evt), 32'd0);
    capture = 1'b0;
    tick(); tick();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noritsuna_counter_core.md
# noritsuna_counter_core

Parametrised successor to the fixed 8-bit counter: a WIDTH-bit programmable counter with prescaler, runtime terminal value, up/down/bounce/hold modes, synchronous load and a single-cycle wrap pulse. It sits behind the TinyTapeout top-level wrapper, which instantiates it with WIDTH=8 and maps `ui_in`/`uio_in` to control and `uo_out` to `count`.

## Interface
- `WIDTH`, 8: counter width in bits, ≥2.
- `PSC_W`, 4: prescaler width in bits, ≥1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  global enable; low freezes the prescaler and counter, but load still acts.
- `mode`  in  2  00 up, 01 down, 10 bounce, 11 hold.
- `load`  in  1  synchronous load strobe, highest priority.
- `load_val`  in  WIDTH  value to load.
- `top`  in  WIDTH  terminal value; counting range is 0..top.
- `prescale`  in  PSC_W  step every prescale+1 enabled cycles.
- `capture`  in  1  capture request, rising-edge sensitive.
- `count`  out  WIDTH  current count, registered.
- `dir`  out  1  1 = counting up, 0 = counting down.
- `wrap`  out  1  one-cycle pulse on terminal event.
- `cap_q`  out  WIDTH  captured count.
- `cap_evt`  out  1  one-cycle pulse when `cap_q` updates.

## Operation
- Reset values: `count`=0, prescaler=0, `dir`=1, `wrap`=0, `cap_q`=0, `cap_evt`=0, capture edge register=0.
- Step generation: when `ena`=1 and `mode`≠11, the prescaler compares to `prescale`.
  - On a match: a step occurs and the prescaler clears.
  - Otherwise: the prescaler increments.
  - `prescale`=0 steps every enabled cycle.
  - Lowering `prescale` below the current prescaler value gives a step on the next enabled cycle (compare is ≥).
- Load (`load`=1):
  - `count` ← min(`load_val`, `top`); prescaler ← 0; no step and no `wrap` that cycle.
  - `dir` is unchanged, except in up mode (forced 1) and down mode (forced 0).
- Up mode, on a step: if `count`≥`top`, then `count`←0 and `wrap`=1; else `count`+1. `dir`=1.
- Down mode, on a step: if `count`=0, then `count`←`top` and `wrap`=1; else `count`−1. `dir`=0.
  - If `count`>`top` after `top` is lowered at runtime, it decrements normally.
- Bounce mode, on a step:
  - Going up with `count`≥`top`: `dir`←0, `count`←`top`−1, `wrap`=1.
  - Going down with `count`=0: `dir`←1, `count`←1, `wrap`=1.
  - Otherwise `count`±1.
  - `top`=0: `count` stays 0, `dir` unchanged, `wrap` pulses every step.
  - `top`=1: alternates 0,1 with `wrap` on each turn.
- Hold mode: `count`, `dir` and prescaler frozen; `wrap`=0.
- A mode change takes effect on the next step; `dir` is updated only on steps or loads.
- All arithmetic is modulo 2^WIDTH. `top`=2^WIDTH−1 gives a full natural wrap.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- `load` at edge N gives the new `count` visible after edge N.
- A step decided at edge N gives the new `count` and `wrap` after edge N. `wrap` is high for exactly one cycle, coincident with the wrapped value.
- `capture`: rising edge detected against a registered copy.
  - `cap_q` ← the `count` value present before the detecting edge.
  - `cap_evt` pulses one cycle, aligned with the new `cap_q`.
  - Capture coinciding with a step captures the pre-step value.
- Reset deassertion mid-operation: counting resumes from 0 with the prescaler at 0. The first step occurs `prescale`+1 enabled cycles later.

## Configuration
- `NORITSUNA_CNT_CAPTURE_EN` defined: the capture edge detector and `cap_q`/`cap_evt` registers are built as described.
- `NORITSUNA_CNT_CAPTURE_EN` undefined: the ports remain; `cap_q`=0 and `cap_evt`=0 constantly; `capture` is ignored; no capture flops are synthesised.

## Structure
- Package `noritsuna_cnt_pkg` contains:
  - the mode typedef `cnt_mode_t` with constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - default parameter constants.
- Sub-module `noritsuna_cnt_prescaler` (PSC_W; `clk`, `rst_n`, `run`, `clr`, `prescale` → `step`). The core drives `run` = `ena` & ~hold and `clr` = `load`.

## Test plan
- Reset, then `ena`=1, up, `top`=5, `prescale`=0 → `count` 0,1,2,3,4,5,0; `wrap` high only on the cycle showing 0.
- Down, `top`=3, `prescale`=2 → `count` changes every 3rd cycle: 0→3 (`wrap`) →2→1→0→3.
- Bounce, `top`=3 from 0 → 1,2,3,2 (`wrap` at 3→2, `dir`→0), 1,0,1 (`wrap` at 0→1, `dir`→1); `top`=0 → `count` stays 0, `wrap` every step.
- `load`=1 with `load_val`=200, `top`=100 → `count`=100 next cycle, no `wrap`, prescaler cleared. `load` with `ena`=0 still loads.
- Up at `count`=50, `top` lowered to 10 → next step gives `count`=0 with `wrap`. `rst_n` pulsed low mid-count → all outputs 0 and `dir`=1 immediately.
- Macro defined: `capture` rising while `count`=7 and a step is pending → `cap_q`=7 and `cap_evt` one cycle. Macro undefined → `cap_q`/`cap_evt` stay 0.
